// File: rtl/biquad_df1.sv
// Direct-form-I biquad: one output sample per 8 cycles through an external 2-cycle signed multiplier.
// Optional output clamping enabled by defining BIQUAD_SATURATE_EN (default: wrap on overflow).
module biquad_df1 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_p,
  input  logic [31:0] x,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] u,
  input  logic [31:0] v,
  output logic [31:0] y
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state;
  logic [2:0]         cnt;
  logic signed [63:0] acc;
  logic signed [63:0] acc_next;
  logic [31:0]        x1, x2, y1, y2;
  logic [31:0]        y_new;

  // Pair (a, x) goes out in the same cycle start is seen, so operand selection is combinational.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (start) begin
            mult_a = a;
            mult_b = x;
          end
        end
        ISSUE: begin
          case (cnt)
            3'd1:    begin mult_a = b; mult_b = x1; end
            3'd2:    begin mult_a = c; mult_b = x2; end
            3'd3:    begin mult_a = u; mult_b = y1; end
            3'd4:    begin mult_a = v; mult_b = y2; end
            default: begin mult_a = '0; mult_b = '0; end
          endcase
        end
        default: begin
          mult_a = '0;
          mult_b = '0;
        end
      endcase
    end
  end

  // Product k lands in cycle k+2: cycles 2..4 carry feed-forward terms, 5..6 feedback terms.
  always_comb begin
    acc_next = acc;
    if ((state == ISSUE && cnt >= 3'd2) || state == DRAIN) begin
      if (cnt <= 3'd4)
        acc_next = acc + $signed(mult_p);
      else
        acc_next = acc - $signed(mult_p);
    end
  end

  always_comb begin
`ifdef BIQUAD_SATURATE_EN
    if (acc_next[63:55] != {9{acc_next[63]}})
      y_new = acc_next[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      y_new = acc_next[55:24];
`else
    y_new = acc_next[55:24];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      y      <= '0;
      finish <= 1'b0;
      x1     <= '0;
      x2     <= '0;
      y1     <= '0;
      y2     <= '0;
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (start) begin
            acc   <= '0;
            cnt   <= 3'd1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          acc <= acc_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd4)
            state <= DRAIN;
        end
        DRAIN: begin
          acc <= acc_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) begin
            y      <= y_new;
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          finish <= 1'b0;
          x2     <= x1;
          x1     <= x;
          y2     <= y1;
          y1     <= y;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_df1.sv
// Directed test of biquad_df1 with a 2-cycle signed multiplier model and hand-computed results.
module tb_biquad_df1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        finish;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_p;
  logic [63:0] p1;
  logic [31:0] x, a, b, c, u, v, y;

  int total = 0;
  int bad   = 0;

  biquad_df1 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .finish (finish),
    .mult_a (mult_a),
    .mult_b (mult_b),
    .mult_p (mult_p),
    .x      (x),
    .a      (a),
    .b      (b),
    .c      (c),
    .u      (u),
    .v      (v),
    .y      (y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1     <= $signed(mult_a) * $signed(mult_b);
    mult_p <= p1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_coef(input logic [31:0] ca, cb, cc, cu, cv);
    a = ca; b = cb; c = cc; u = cu; v = cv;
  endtask

  // Issues one sample, returns cycles from start to finish and the y seen with finish; ends back in IDLE.
  task automatic run_sample(input logic [31:0] xv, output int lat, output logic [31:0] yv);
    x = xv;
    start = 1'b1;
    lat = 0;
    yv = 'x;
    while (lat < 20) begin
      tick();
      lat++;
      start = 1'b0;
      if (finish) break;
    end
    yv = y;
    tick();
  endtask

  int          lat;
  logic [31:0] yv;
  int          fin_cnt;
  logic [31:0] ea, eb;
  logic [31:0] mx1, mx2, my1, my2;
  logic [31:0] ey [3];

  initial begin
    rst = 1'b1; start = 1'b0; x = '0;
    set_coef(0, 0, 0, 0, 0);
    do_reset();
    chk("rst_y", y, 0);
    chk("rst_finish", finish, 0);
    chk("rst_ma", mult_a, 0);
    chk("rst_mb", mult_b, 0);

    // passthrough
    set_coef(32'h0100_0000, 0, 0, 0, 0);
    run_sample(32'd1048576, lat, yv);
    chk("pass_lat", lat, 7);
    chk("pass_y", yv, 32'd1048576);
    chk("pass_idle_finish", finish, 0);

    // one-sample delay
    do_reset();
    set_coef(0, 32'h0100_0000, 0, 0, 0);
    run_sample(32'd5, lat, yv);
    chk("delay_y0", yv, 0);
    run_sample(32'd7, lat, yv);
    chk("delay_y1", yv, 32'd5);
    chk("delay_lat", lat, 7);

    // feedback y = x + 0.5*y1
    do_reset();
    set_coef(32'h0100_0000, 0, 0, 32'hFF80_0000, 0);
    run_sample(32'h0100_0000, lat, yv);
    chk("fb_y0", yv, 32'h0100_0000);
    run_sample(32'h0100_0000, lat, yv);
    chk("fb_y1", yv, 32'h0180_0000);
    run_sample(32'h0100_0000, lat, yv);
    chk("fb_y2", yv, 32'h01C0_0000);

    // overflow
    do_reset();
    set_coef(32'h7FFF_FFFF, 0, 0, 0, 0);
    run_sample(32'h7FFF_FFFF, lat, yv);
`ifdef BIQUAD_SATURATE_EN
    chk("ovf_y", yv, 32'h7FFF_FFFF);
`else
    chk("ovf_y", yv, 32'hFFFF_FF00);
`endif

    // reset during computation
    do_reset();
    set_coef(32'h0100_0000, 32'h0100_0000, 0, 0, 0);
    run_sample(32'd9, lat, yv);
    chk("abort_pre_y", yv, 32'd9);
    x = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_rst_ma", mult_a, 0);
    chk("abort_rst_mb", mult_b, 0);
    tick();
    rst = 1'b0;
    fin_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (finish) fin_cnt++;
      tick();
    end
    chk("abort_no_finish", fin_cnt, 0);
    chk("abort_y", y, 0);
    run_sample(32'd3, lat, yv);
    chk("abort_next_y", yv, 32'd3);
    chk("abort_next_lat", lat, 7);

    // back-to-back with start held high
    do_reset();
    set_coef(32'h0100_0000, 32'h0080_0000, 32'h0040_0000, 32'h0020_0000, 32'h0010_0000);
    x = 32'h0100_0000;
    ey[0] = 32'h0100_0000;
    ey[1] = 32'h0160_0000;
    ey[2] = 32'h0184_0000;
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    start = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      for (int cy = 0; cy < 8; cy++) begin
        case (cy)
          0:       begin ea = a; eb = x;   end
          1:       begin ea = b; eb = mx1; end
          2:       begin ea = c; eb = mx2; end
          3:       begin ea = u; eb = my1; end
          4:       begin ea = v; eb = my2; end
          default: begin ea = 0; eb = 0;   end
        endcase
        chk($sformatf("b2b_ma_s%0d_c%0d", s, cy), mult_a, ea);
        chk($sformatf("b2b_mb_s%0d_c%0d", s, cy), mult_b, eb);
        chk($sformatf("b2b_fin_s%0d_c%0d", s, cy), finish, (cy == 7) ? 1 : 0);
        if (cy == 7)
          chk($sformatf("b2b_y_s%0d", s), y, ey[s]);
        tick();
      end
      mx2 = mx1; mx1 = x; my2 = my1; my1 = ey[s];
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biquad_df1.md
BIQUAD_DF1 -- requirements
Module: biquad

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request one output sample; sampled only in IDLE.
REQ-004 SHALL have port finish, output, 1 bit: one-cycle pulse, y valid.
REQ-005 SHALL have ports mult_a and mult_b, output, 32 bits each: signed operands to the shared multiplier.
REQ-006 SHALL have port mult_p, input, 64 bits: signed product from the shared multiplier, valid 2 cycles after operands are driven.
REQ-007 SHALL have port x, input, 32 bits: signed input sample, exponent -24, stable from start until finish.
REQ-008 SHALL have ports a, b, c, input, 32 bits each: signed feed-forward coefficients, exponent -24 (Q8.24), stable during computation.
REQ-009 SHALL have ports u, v, input, 32 bits each: signed feedback coefficients, Q8.24, stable during computation.
REQ-010 SHALL have port y, output, 32 bits: signed output sample, exponent -24, held until next finish.

Function
REQ-011 SHALL compute direct form I: y = a*x + b*x1 + c*x2 - u*y1 - v*y2, where x1, x2, y1, y2 are internal histories.
REQ-012 SHALL use states IDLE, ISSUE (4 cycles), DRAIN (2 cycles), DONE (1 cycle).
REQ-013 SHALL, in IDLE with start=1 (cycle 0), drive the pair (a, x), then (b, x1), (c, x2), (u, y1), (v, y2) in cycles 1-4.
REQ-014 SHALL drive mult_a = mult_b = 0 in every cycle with no pair issued.
REQ-015 SHALL accumulate in a 64-bit signed register (exponent -48): product k read from mult_p in cycle k+2; products 0-2 added, products 3-4 subtracted.
REQ-016 SHALL, at the end of cycle 6, register y = accumulator bits [55:24], saturated per REQ-024.
REQ-017 SHALL assert finish for exactly cycle 7, the DONE state.
REQ-018 SHALL, at the end of cycle 7, shift histories: x2<=x1, x1<=x, y2<=y1, y1<=y, then enter IDLE.
REQ-019 SHALL ignore start outside IDLE; start high in the cycle after finish begins the next sample immediately (8-cycle throughput).
REQ-020 SHALL assume the shared multiplier is a signed 32x32->64 multiplier with exactly 2-cycle latency; no divider is used.

Reset
REQ-021 SHALL, on rst, go to IDLE and clear y, finish, accumulator, x1, x2, y1, y2 to 0.
REQ-022 SHALL let rst override everything else: no finish pulse for an aborted computation, histories left at 0.
REQ-023 SHALL drive mult_a = mult_b = 0 while rst is high.

Configuration
REQ-024 SHALL, with BIQUAD_SATURATE_EN defined, clamp y to 0x7FFFFFFF or 0x80000000 when accumulator bits [63:55] are not all equal.
REQ-025 SHALL, without BIQUAD_SATURATE_EN, take y = accumulator[55:24] and wrap on overflow.

Verification
REQ-026 SHALL cover passthrough: a=0x01000000, other coefficients 0, x=1048576 -> y=1048576, finish exactly 7 cycles after start is sampled.
REQ-027 SHALL cover delay: b=0x01000000, others 0, x=5 then x=7 -> y=0 then y=5.
REQ-028 SHALL cover feedback: a=0x01000000, u=0xFF800000 (-0.5), x=0x01000000 for three samples -> y=0x01000000, 0x01800000, 0x01C00000.
REQ-029 SHALL cover overflow: a=0x7FFFFFFF, x=0x7FFFFFFF -> y=0x7FFFFFFF with BIQUAD_SATURATE_EN; wrapped bits [55:24] without it.
REQ-030 SHALL cover reset: rst at cycle 3 of a computation -> no finish, y=0; next sample behaves as the first after reset.
REQ-031 SHALL cover back-to-back: start held high across finish -> finish pulses every 8 cycles, mult_a/mult_b sequence matches REQ-013.
